// File: rtl/gpr_writeback_pkg.sv
// gpr_writeback_pkg: shared XLEN and writeback grant encoding
package gpr_writeback_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} wb_src_e;
endpackage

// File: rtl/wb_arbiter.sv
// wb_arbiter: LSU-priority writeback arbiter with ALU starvation guard
module wb_arbiter
    import gpr_writeback_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    alu_valid,
    input  logic    lsu_valid,
    output logic    alu_ready,
    output logic    lsu_ready,
    output wb_src_e grant
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;
    logic          at_limit;
    logic          alu_win;
    assign at_limit  = starve_cnt == SW'(STARVE_LIMIT);
    assign alu_win   = !lsu_valid || (alu_valid && at_limit);
    // a source with no competing valid stays ready even when idle
    assign alu_ready = rst && alu_win;
    assign lsu_ready = rst && (!alu_valid || !alu_win);
    assign grant     = (alu_valid && alu_ready) ? WB_ALU :
                       (lsu_valid && lsu_ready) ? WB_LSU : WB_NONE;
    always_ff @(posedge clk or negedge rst)
        if (!rst) starve_cnt <= '0;
        else if (!alu_valid || grant == WB_ALU) starve_cnt <= '0;
        else if (lsu_valid && !at_limit) starve_cnt <= starve_cnt + 1'b1;
endmodule

// File: rtl/gpr_writeback.sv
// gpr_writeback: arbitrates ALU/LSU results into a registered GPR write port
module gpr_writeback
    import gpr_writeback_pkg::*;
#(
    parameter int          STARVE_LIMIT  = 4,
    parameter logic [31:0] WB_COUNT_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic [4:0]      reg_wnum,
    output logic            reg_wen,
    output logic [XLEN-1:0] rwdata,
    output logic [31:0]     wb_count
);
    wb_src_e         grant;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            hs;
    logic            wr;
    wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .lsu_valid (lsu_valid),
        .alu_ready (alu_ready),
        .lsu_ready (lsu_ready),
        .grant     (grant)
    );
    assign rd   = grant == WB_ALU ? alu_rd : lsu_rd;
    assign data = grant == WB_ALU ? alu_data : lsu_data;
    assign hs   = grant != WB_NONE;
    // writes to x0 retire normally but never reach the register file
    assign wr   = hs && rd != 5'd0;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            reg_wen  <= 1'b0;
            reg_wnum <= '0;
            rwdata   <= '0;
            wb_count <= WB_COUNT_INIT;
        end else begin
            reg_wen <= wr;
            if (hs) begin
                reg_wnum <= rd;
                rwdata   <= data;
            end
            if (wr) wb_count <= wb_count + 32'd1;
        end
endmodule

// File: tb/tb_gpr_writeback.sv
// tb_gpr_writeback: table-driven check of arbitration, writeback timing, x0, wrap and reset
module tb_gpr_writeback;
    import gpr_writeback_pkg::*;
    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ar;
        logic        lr;
        logic        wen;
        logic [4:0]  wn;
        logic [31:0] wd;
        logic [31:0] cnt;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        alu_ready, lsu_ready, reg_wen;
    logic [4:0]  reg_wnum;
    logic [31:0] rwdata, wb_count;
    logic        w_alu_ready, w_lsu_ready, w_reg_wen;
    logic [4:0]  w_reg_wnum;
    logic [31:0] w_rwdata, w_wb_count;
    int          total = 0;
    int          passed = 0;
    vec_t        vt[$];
    always #5 clk = ~clk;
    gpr_writeback #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .reg_wnum(reg_wnum), .reg_wen(reg_wen), .rwdata(rwdata), .wb_count(wb_count)
    );
    gpr_writeback #(.STARVE_LIMIT(4), .WB_COUNT_INIT(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(w_alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(w_lsu_ready),
        .reg_wnum(w_reg_wnum), .reg_wen(w_reg_wen), .rwdata(w_rwdata), .wb_count(w_wb_count)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                                input logic ar, input logic lr, input logic wen,
                                input logic [4:0] wn, input logic [31:0] wd, input logic [31:0] cnt);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.ar = ar; v.lr = lr; v.wen = wen; v.wn = wn; v.wd = wd; v.cnt = cnt;
        return v;
    endfunction
    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    endtask
    initial begin
        vt.push_back(mk(1, 5, 32'h1234, 0, 0, 0,           1, 0, 1, 5,  32'h1234, 1));
        vt.push_back(mk(0, 0, 0,        1, 0, 32'hDEAD,    0, 1, 0, 0,  32'hDEAD, 1));
        vt.push_back(mk(0, 0, 0,        0, 0, 0,           1, 1, 0, 0,  32'hDEAD, 1));
        vt.push_back(mk(1, 1, 32'hA1,   1, 2, 32'hB2,      0, 1, 1, 2,  32'hB2,   2));
        vt.push_back(mk(1, 1, 32'hA1,   1, 3, 32'hB3,      0, 1, 1, 3,  32'hB3,   3));
        vt.push_back(mk(1, 1, 32'hA1,   1, 4, 32'hB4,      0, 1, 1, 4,  32'hB4,   4));
        vt.push_back(mk(1, 1, 32'hA1,   1, 6, 32'hB6,      0, 1, 1, 6,  32'hB6,   5));
        vt.push_back(mk(1, 1, 32'hA1,   1, 9, 32'hB9,      1, 0, 1, 1,  32'hA1,   6));
        vt.push_back(mk(1, 1, 32'hA1,   1, 2, 32'hC2,      0, 1, 1, 2,  32'hC2,   7));
        vt.push_back(mk(1, 1, 32'hA1,   1, 3, 32'hC3,      0, 1, 1, 3,  32'hC3,   8));
        vt.push_back(mk(1, 1, 32'hA1,   1, 4, 32'hC4,      0, 1, 1, 4,  32'hC4,   9));
        vt.push_back(mk(1, 8, 32'h88,   0, 0, 0,           1, 0, 1, 8,  32'h88,   10));
        vt.push_back(mk(1, 1, 32'hA1,   1, 10, 32'hD0,     0, 1, 1, 10, 32'hD0,   11));
        vt.push_back(mk(1, 1, 32'hA1,   1, 11, 32'hD1,     0, 1, 1, 11, 32'hD1,   12));
        vt.push_back(mk(1, 1, 32'hA1,   1, 12, 32'hD2,     0, 1, 1, 12, 32'hD2,   13));
        vt.push_back(mk(1, 1, 32'hA1,   1, 13, 32'hD3,     0, 1, 1, 13, 32'hD3,   14));
        vt.push_back(mk(1, 1, 32'hA1,   1, 14, 32'hD4,     1, 0, 1, 1,  32'hA1,   15));
        vt.push_back(mk(0, 0, 0,        1, 7, 32'hE1,      0, 1, 1, 7,  32'hE1,   16));
        vt.push_back(mk(0, 0, 0,        1, 7, 32'hE2,      0, 1, 1, 7,  32'hE2,   17));
        #1;
        chk("rst_wen", reg_wen, 0);
        chk("rst_wnum", reg_wnum, 0);
        chk("rst_wdata", rwdata, 0);
        chk("rst_cnt", wb_count, 0);
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_lsu_ready", lsu_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].av, vt[i].ard, vt[i].ad, vt[i].lv, vt[i].lrd, vt[i].ld);
            #1;
            chk($sformatf("v%0d_alu_ready", i), alu_ready, vt[i].ar);
            chk($sformatf("v%0d_lsu_ready", i), lsu_ready, vt[i].lr);
            @(posedge clk); #1;
            chk($sformatf("v%0d_wen", i), reg_wen, vt[i].wen);
            chk($sformatf("v%0d_wnum", i), reg_wnum, vt[i].wn);
            chk($sformatf("v%0d_wdata", i), rwdata, vt[i].wd);
            chk($sformatf("v%0d_cnt", i), wb_count, vt[i].cnt);
            chk($sformatf("v%0d_wrap_wen", i), w_reg_wen, vt[i].wen);
            chk($sformatf("v%0d_wrap_cnt", i), w_wb_count, 32'hFFFF_FFFE + vt[i].cnt);
        end
        drive(0, 0, 0, 1, 7, 32'h77);
        #1;
        chk("x7_lsu_ready", lsu_ready, 1);
        @(posedge clk); #1;
        chk("x7_wen", reg_wen, 1);
        chk("x7_wnum", reg_wnum, 7);
        #2;
        rst = 1'b0;
        #1;
        chk("async_wen", reg_wen, 0);
        chk("async_wnum", reg_wnum, 0);
        chk("async_wdata", rwdata, 0);
        chk("async_cnt", wb_count, 0);
        chk("async_lsu_ready", lsu_ready, 0);
        chk("async_alu_ready", alu_ready, 0);
        @(posedge clk); #1;
        chk("held_wen", reg_wen, 0);
        chk("held_wnum", reg_wnum, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_wen", reg_wen, 0);
        chk("post_rst_wnum", reg_wnum, 0);
        chk("post_rst_cnt", wb_count, 0);
        drive(1, 3, 32'h33, 0, 0, 0);
        @(posedge clk); #1;
        chk("first_wen", reg_wen, 1);
        chk("first_wnum", reg_wnum, 3);
        chk("first_wdata", rwdata, 32'h33);
        chk("first_cnt", wb_count, 1);
        chk("first_wrap_cnt", w_wb_count, 32'hFFFF_FFFF);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("idle_wen", reg_wen, 0);
        chk("idle_wnum_hold", reg_wnum, 3);
        chk("idle_wdata_hold", rwdata, 32'h33);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gpr_writeback.md
GPR_WRITEBACK -- requirements
Module: gpr_writeback

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive ALU losses before the ALU is forced to win.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 alu_valid  input  1  ALU result offered.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  XLEN  ALU result.
REQ-007 alu_ready  output  1  ALU result accepted this cycle when alu_valid is also high.
REQ-008 lsu_valid  input  1  load result offered.
REQ-009 lsu_rd  input  5  load destination register.
REQ-010 lsu_data  input  XLEN  load data.
REQ-011 lsu_ready  output  1  load result accepted this cycle when lsu_valid is also high.
REQ-012 reg_wnum  output  5  register-file write index.
REQ-013 reg_wen  output  1  register-file write enable.
REQ-014 rwdata  output  XLEN  register-file write data.
REQ-015 wb_count  output  32  count of retired non-x0 writes.

Function
REQ-016 A source handshake SHALL complete only in a cycle where its valid and ready are both high; at most one handshake per cycle.
REQ-017 Arbitration SHALL be combinational from current valids and starve_cnt: LSU wins by default; ALU wins when lsu_valid is low, or when alu_valid is high and starve_cnt == STARVE_LIMIT.
REQ-018 The ready of the losing source SHALL be low; the ready of a source with no competitor SHALL be high, independent of its own valid.
REQ-019 starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, when alu_valid and lsu_valid are high and LSU wins.
REQ-020 starve_cnt SHALL clear to 0 on an ALU handshake or in any cycle with alu_valid low.
REQ-021 reg_wnum, reg_wen and rwdata SHALL be registered: the winning rd/data appear exactly one cycle after the handshake.
REQ-022 A handshake with rd == 0 SHALL be accepted normally but SHALL produce reg_wen = 0 the following cycle; reg_wnum/rwdata still update.
REQ-023 With no handshake in a cycle, reg_wen SHALL be 0 the next cycle and reg_wnum/rwdata SHALL hold their previous values.
REQ-024 wb_count SHALL increment by 1 in each cycle reg_wen is 1, wrapping from 0xFFFFFFFF to 0.
REQ-025 Two back-to-back handshakes to the same rd SHALL produce two consecutive writes; no merging or reordering.

Reset
REQ-026 While rst is low: reg_wen = 0, reg_wnum = 0, rwdata = 0, wb_count = 0, starve_cnt = 0, asynchronously.
REQ-027 alu_ready/lsu_ready SHALL be 0 while rst is low; a handshake in flight at reset assertion SHALL be dropped with no write after release.
REQ-028 The first handshake SHALL be possible in the first rising edge with rst high.

Structure
REQ-029 XLEN SHALL come from the shared common definitions; a shared package SHALL hold enum wb_src_e {WB_NONE, WB_ALU, WB_LSU} used for the grant.
REQ-030 The block SHALL be a single module; the arbiter plus starvation counter MAY be split into sub-module wb_arbiter.

Verification
REQ-031 Only alu_valid, rd=5, data=0x1234 -> alu_ready=1; next cycle reg_wen=1, reg_wnum=5, rwdata=0x1234, wb_count=1.
REQ-032 Both valid every cycle, STARVE_LIMIT=4, distinct rds -> LSU wins 4 cycles, ALU wins 5th, pattern repeats (4 LSU : 1 ALU).
REQ-033 lsu_valid with rd=0, data=0xDEAD -> lsu_ready=1; next cycle reg_wen=0, wb_count unchanged.
REQ-034 LSU handshake rd=7 then rst pulled low mid-cycle -> all outputs 0 immediately; no write to x7 after release.
REQ-035 Preload wb_count near 0xFFFFFFFF by 2 writes -> counter wraps to 0 on the 2nd write with reg_wen pulses correct.
REQ-036 ALU valid, LSU valid 3 cycles then drops -> ALU accepted the cycle LSU drops, starve_cnt back to 0.
